sl_transmitter: RTL and testbench



---
 rtl/sl_transmitter_pkg.sv | 50 +++++
 rtl/sl_transmitter_if.sv | 12 +
 rtl/sl_transmitter_phase_timer.sv | 36 +++
 rtl/sl_transmitter.sv | 227 ++++++++++++++++++++++
 tb/tb_sl_transmitter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sl_transmitter_pkg.sv
// Shared types, config field layout and helpers for the serial-line transmitter.
package sl_pkg;

  localparam int DATA_W = 32;
  localparam int CFG_W  = 16;

  localparam int CFG_INV_BIT  = 0;
  localparam int CFG_LEN_LSB  = 1;
  localparam int CFG_LEN_W    = 6;
  localparam int CFG_FREQ_LSB = 7;
  localparam int CFG_FREQ_W   = 2;

  localparam logic [CFG_W-1:0] CFG_USED_MASK = 16'h01FF;
  localparam logic [CFG_W-1:0] CFG_RESET     = 16'h0110;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_BIT_PRE   = 4'd1,
    ST_BIT_LOW   = 4'd2,
    ST_BIT_POST  = 4'd3,
    ST_PAR_PRE   = 4'd4,
    ST_PAR       = 4'd5,
    ST_PAR_POST  = 4'd6,
    ST_STOP      = 4'd7,
    ST_STOP_POST = 4'd8
  } sl_state_e;

  function automatic logic [6:0] sl_period(input logic [CFG_FREQ_W-1:0] freq_sel);
    logic [6:0] p;
    case (freq_sel)
      2'b00:   p = 7'd8;
      2'b01:   p = 7'd16;
      2'b10:   p = 7'd32;
      2'b11:   p = 7'd64;
      default: p = 7'd8;
    endcase
    return p;
  endfunction

  function automatic logic sl_len_ok(input logic [CFG_LEN_W-1:0] len);
    return (len[0] == 1'b0) && (len >= 6'd8) && (len <= 6'd32);
  endfunction

  function automatic logic [DATA_W-1:0] sl_len_mask(input logic [CFG_LEN_W-1:0] len);
    logic [DATA_W:0] m;
    m = (33'd1 << len) - 33'd1;
    return m[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/sl_transmitter_if.sv
// Word handshake between a data source and the serial-line transmitter.
interface sl_transmitter_if;
  import sl_pkg::*;

  logic [DATA_W-1:0] data_w;
  logic              data_valid;
  logic              tx_ready;
  logic              word_sent;

  modport master (output data_w, output data_valid, input tx_ready, input word_sent);
  modport slave  (input data_w, input data_valid, output tx_ready, output word_sent);
endinterface

// File: rtl/sl_transmitter_phase_timer.sv
// Loadable phase down-counter; done is high while the count sits at zero.
module sl_phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [5:0] load_val_i,
  output logic       done_o
);

  logic [5:0] cnt_q;
  logic [5:0] cnt_d;

  // Next count: reload, else count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 6'd0) begin
      cnt_d = cnt_q - 6'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 6'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 6'd0);

endmodule

// File: rtl/sl_transmitter.sv
// Serial-line transmitter: config register, per-frame shadow copy and the
// frame FSM that drives the active-low zeroes/ones line pair.
module sl_transmitter
  import sl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_enable,
  input  logic [CFG_W-1:0]    wr_config_w,
  output logic [CFG_W-1:0]    r_config_w,
  sl_transmitter_if.slave     tx,
  output logic                serial_line_zeroes,
  output logic                serial_line_ones,
  output logic [CFG_W-1:0]    status_w
);

  logic [CFG_W-1:0]     cfg_q, cfg_d;
  logic                 cfg_err_q, cfg_err_d;

  sl_state_e            state_q;
  logic                 zeroes_q, ones_q;
  logic                 tx_ready_q, word_sent_q;
  logic [DATA_W-1:0]    shift_q;
  logic [CFG_LEN_W-1:0] bit_cnt_q;
  logic [5:0]           per_m1_q;
  logic                 par_z_q, par_o_q;

  logic                 accept_s;
  logic [CFG_LEN_W-1:0] cfg_len_s;
  logic                 cfg_inv_s;
  logic [6:0]           cfg_per_s;
  logic [5:0]           cfg_per_m1_s;
  logic [DATA_W-1:0]    mask_s;
  logic                 tmr_load_s, tmr_done_s;
  logic [5:0]           tmr_val_s;

  assign accept_s     = tx.data_valid & tx_ready_q;
  assign cfg_len_s    = cfg_q[CFG_LEN_LSB +: CFG_LEN_W];
  assign cfg_inv_s    = cfg_q[CFG_INV_BIT];
  assign cfg_per_s    = sl_period(cfg_q[CFG_FREQ_LSB +: CFG_FREQ_W]);
  assign cfg_per_m1_s = 6'(cfg_per_s - 7'd1);
  assign mask_s       = sl_len_mask(cfg_len_s);

  // Config write: legal lengths update the register, anything else only flags.
  always_comb begin
    cfg_d     = cfg_q;
    cfg_err_d = cfg_err_q;
    if (wr_enable) begin
      if (sl_len_ok(wr_config_w[CFG_LEN_LSB +: CFG_LEN_W])) begin
        cfg_d     = wr_config_w & CFG_USED_MASK;
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else begin
      cfg_d     = cfg_q;
      cfg_err_d = cfg_err_q;
    end
  end

  // Config and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q     <= CFG_RESET;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Timer reload value is the duration of the state being entered (H = T/2).
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = 6'd0;
    case (state_q)
      ST_IDLE: begin
        tmr_load_s = accept_s;
        tmr_val_s  = cfg_per_m1_s >> 1;
      end
      ST_BIT_PRE, ST_PAR_PRE, ST_PAR, ST_PAR_POST: begin
        tmr_load_s = tmr_done_s;
        tmr_val_s  = per_m1_q;
      end
      ST_BIT_LOW, ST_BIT_POST, ST_STOP: begin
        tmr_load_s = tmr_done_s;
        tmr_val_s  = per_m1_q >> 1;
      end
      default: begin
        tmr_load_s = 1'b0;
        tmr_val_s  = 6'd0;
      end
    endcase
  end

  sl_phase_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .done_o     (tmr_done_s)
  );

  // Frame FSM; line levels are registered together with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      zeroes_q    <= 1'b1;
      ones_q      <= 1'b1;
      tx_ready_q  <= 1'b1;
      word_sent_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= 6'd0;
      per_m1_q    <= 6'd0;
      par_z_q     <= 1'b1;
      par_o_q     <= 1'b1;
    end else begin
      word_sent_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            shift_q    <= tx.data_w;
            bit_cnt_q  <= cfg_len_s;
            per_m1_q   <= cfg_per_m1_s;
            // p0 counts zero bits (inverted), p1 counts one bits, both over length bits only.
            par_z_q    <= ~(^(~tx.data_w & mask_s)) ^ cfg_inv_s;
            par_o_q    <= (^(tx.data_w & mask_s)) ^ cfg_inv_s;
            tx_ready_q <= 1'b0;
            state_q    <= ST_BIT_PRE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BIT_PRE: begin
          if (tmr_done_s) begin
            zeroes_q <= shift_q[0];
            ones_q   <= ~shift_q[0];
            state_q  <= ST_BIT_LOW;
          end else begin
            state_q <= ST_BIT_PRE;
          end
        end
        ST_BIT_LOW: begin
          if (tmr_done_s) begin
            zeroes_q <= 1'b1;
            ones_q   <= 1'b1;
            state_q  <= ST_BIT_POST;
          end else begin
            state_q <= ST_BIT_LOW;
          end
        end
        ST_BIT_POST: begin
          if (tmr_done_s) begin
            if (bit_cnt_q == 6'd1) begin
              state_q <= ST_PAR_PRE;
            end else begin
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q - 6'd1;
              state_q   <= ST_BIT_PRE;
            end
          end else begin
            state_q <= ST_BIT_POST;
          end
        end
        ST_PAR_PRE: begin
          if (tmr_done_s) begin
            zeroes_q <= par_z_q;
            ones_q   <= par_o_q;
            state_q  <= ST_PAR;
          end else begin
            state_q <= ST_PAR_PRE;
          end
        end
        ST_PAR: begin
          if (tmr_done_s) begin
            zeroes_q <= 1'b1;
            ones_q   <= 1'b1;
            state_q  <= ST_PAR_POST;
          end else begin
            state_q <= ST_PAR;
          end
        end
        ST_PAR_POST: begin
          if (tmr_done_s) begin
            zeroes_q <= 1'b0;
            ones_q   <= 1'b0;
            state_q  <= ST_STOP;
          end else begin
            state_q <= ST_PAR_POST;
          end
        end
        ST_STOP: begin
          if (tmr_done_s) begin
            zeroes_q <= 1'b1;
            ones_q   <= 1'b1;
            state_q  <= ST_STOP_POST;
          end else begin
            state_q <= ST_STOP;
          end
        end
        ST_STOP_POST: begin
          if (tmr_done_s) begin
            word_sent_q <= 1'b1;
            tx_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            state_q <= ST_STOP_POST;
          end
        end
        default: begin
          zeroes_q   <= 1'b1;
          ones_q     <= 1'b1;
          tx_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign serial_line_zeroes = zeroes_q;
  assign serial_line_ones   = ones_q;
  assign tx.tx_ready        = tx_ready_q;
  assign tx.word_sent       = word_sent_q;
  assign r_config_w         = cfg_q;
  assign status_w           = {14'd0, cfg_err_q, ~tx_ready_q};

endmodule

// File: tb/tb_sl_transmitter.sv
// Randomised bench for sl_transmitter: a per-cycle line-level model built from
// the frame rules, compared every cycle, plus a few literal waveform points.
module tb_sl_transmitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_enable;
  logic [15:0] wr_config_w;
  logic [15:0] r_config_w;
  logic [15:0] status_w;
  logic        zl, ol;

  sl_transmitter_if tx_if ();

  always #5 clk = ~clk;

  sl_transmitter dut (
    .clk                (clk),
    .rst                (rst),
    .wr_enable          (wr_enable),
    .wr_config_w        (wr_config_w),
    .r_config_w         (r_config_w),
    .tx                 (tx_if),
    .serial_line_zeroes (zl),
    .serial_line_ones   (ol),
    .status_w           (status_w)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0]  exp_q[$];
  logic        m_busy;
  logic [1:0]  m_cur;
  logic        m_ws;
  logic [15:0] m_cfg;
  logic        m_err;
  int          off;
  int          acc_cnt;
  int          ws_at;
  logic [1:0]  rec[0:255];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected {zeroes,ones} for every cycle of one frame, from the cycle after accept.
  task automatic build_frame(input logic [31:0] d, input logic [15:0] cfg);
    int t, h, len, n1, n0;
    logic z, o, inv;
    t = 8 << int'(cfg[8:7]);
    h = t / 2;
    len = int'(cfg[6:1]);
    inv = cfg[0];
    n1 = 0; n0 = 0;
    for (int i = 0; i < len; i++) begin
      if (d[i]) n1++; else n0++;
      for (int k = 0; k < h; k++) exp_q.push_back(2'b11);
      for (int k = 0; k < t; k++) exp_q.push_back(d[i] ? 2'b10 : 2'b01);
      for (int k = 0; k < h; k++) exp_q.push_back(2'b11);
    end
    z = 1'b1 ^ logic'(n0 % 2) ^ inv;
    o = logic'(n1 % 2) ^ inv;
    for (int k = 0; k < h; k++) exp_q.push_back(2'b11);
    for (int k = 0; k < t; k++) exp_q.push_back({z, o});
    for (int k = 0; k < t; k++) exp_q.push_back(2'b11);
    for (int k = 0; k < t; k++) exp_q.push_back(2'b00);
    for (int k = 0; k < h; k++) exp_q.push_back(2'b11);
  endtask

  // One clock: advance the model at the edge, compare all outputs half a cycle later.
  task automatic step();
    int len;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_busy = 1'b0; m_cur = 2'b11; m_ws = 1'b0;
      m_cfg = 16'h0110; m_err = 1'b0;
    end else begin
      m_ws = 1'b0;
      if (!m_busy && tx_if.data_valid) begin
        build_frame(tx_if.data_w, m_cfg);
        off = 0;
        acc_cnt++;
      end
      if (wr_enable) begin
        len = int'(wr_config_w[6:1]);
        if (len % 2 == 0 && len >= 8 && len <= 32) begin
          m_cfg = {7'd0, wr_config_w[8:0]};
          m_err = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
      if (exp_q.size() > 0) begin
        m_cur = exp_q.pop_front();
        m_busy = 1'b1;
      end else begin
        if (m_busy) m_ws = 1'b1;
        m_busy = 1'b0;
        m_cur = 2'b11;
      end
    end
    off++;
    @(negedge clk);
    chk("lines", {30'd0, zl, ol}, {30'd0, m_cur});
    chk("tx_ready", {31'd0, tx_if.tx_ready}, {31'd0, ~m_busy});
    chk("word_sent", {31'd0, tx_if.word_sent}, {31'd0, m_ws});
    chk("status", {16'd0, status_w}, {16'd0, 14'd0, m_err, m_busy});
    chk("r_config", {16'd0, r_config_w}, {16'd0, m_cfg});
    if (off < 256) rec[off] = {zl, ol};
    if (tx_if.word_sent) ws_at = off;
  endtask

  task automatic write_cfg(input logic [15:0] w);
    wr_enable = 1'b1; wr_config_w = w;
    step();
    wr_enable = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    int a0;
    a0 = acc_cnt;
    tx_if.data_valid = 1'b1; tx_if.data_w = d;
    for (int c = 0; c < 4 && acc_cnt == a0; c++) step();
    tx_if.data_valid = 1'b0;
    chk("accept_timeout", acc_cnt, a0 + 1);
  endtask

  // Run to end of frame, optionally with a random config write and idle valid pulses mid-frame.
  task automatic finish_frame(input bit noise);
    int budget, mid;
    budget = exp_q.size() + 8;
    mid = (exp_q.size() > 2) ? int'($urandom_range(1, exp_q.size() - 1)) : 1;
    for (int c = 0; c < budget && m_busy; c++) begin
      wr_enable = noise && (c == mid);
      wr_config_w = 16'($urandom);
      tx_if.data_valid = noise && (exp_q.size() > 4) && ($urandom_range(0, 3) == 0);
      tx_if.data_w = $urandom;
      step();
    end
    wr_enable = 1'b0; tx_if.data_valid = 1'b0;
    chk("frame_timeout", {31'd0, m_busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] cfg;
    int a0;
    rst = 1'b1; wr_enable = 1'b0; wr_config_w = 16'h0000;
    tx_if.data_valid = 1'b0; tx_if.data_w = 32'h0;
    acc_cnt = 0; off = 0; ws_at = -1;
    m_busy = 1'b0; m_cur = 2'b11; m_ws = 1'b0; m_cfg = 16'h0110; m_err = 1'b0;
    step(); step();
    chk("reset_cfg", {16'd0, r_config_w}, 32'h0110);
    chk("reset_lines", {30'd0, zl, ol}, 32'd3);
    chk("reset_status", {16'd0, status_w}, 32'd0);
    chk("reset_ready", {31'd0, tx_if.tx_ready}, 32'd1);
    rst = 1'b0;
    step();

    // Length 8, T=8, 0xA5: literal waveform points.
    write_cfg(16'h0010);
    ws_at = -1;
    send(32'h0000_00A5);
    finish_frame(1'b0);
    chk("a5_pre", {30'd0, rec[4]}, 32'd3);
    chk("a5_cell0", {30'd0, rec[5]}, 32'd2);
    chk("a5_cell1", {30'd0, rec[21]}, 32'd1);
    chk("a5_cell3", {30'd0, rec[53]}, 32'd1);
    chk("a5_cell7", {30'd0, rec[117]}, 32'd2);
    chk("a5_par", {30'd0, rec[133]}, 32'd2);
    chk("a5_stop", {30'd0, rec[150]}, 32'd0);
    chk("a5_ws_at", ws_at, 161);

    // Illegal lengths flag cfg_err without touching the register.
    write_cfg(16'h0012);
    chk("len9_status", {16'd0, status_w}, 32'd2);
    chk("len9_cfg", {16'd0, r_config_w}, 32'h0010);
    write_cfg(16'h0044);
    chk("len34_status", {16'd0, status_w}, 32'd2);
    write_cfg(16'h0011);
    chk("err_cleared", {16'd0, status_w}, 32'd0);

    // Inverted parity.
    send(32'h0000_00A5);
    finish_frame(1'b0);
    chk("a5_par_inv", {30'd0, rec[133]}, 32'd1);

    // Random sweep with mid-frame config writes and held-off valid.
    for (int fs = 0; fs < 4; fs++) begin
      for (int len = 8; len <= 32; len += 2) begin
        if (fs == 3 && len != 8 && len != 32) continue;
        cfg = {7'd0, 2'(fs), 6'(len), 1'($urandom_range(0, 1))};
        write_cfg(cfg);
        if ($urandom_range(0, 3) == 0) begin
          // Write lands on the accept edge: the frame must use the old config.
          tx_if.data_valid = 1'b1; tx_if.data_w = $urandom;
          wr_enable = 1'b1; wr_config_w = {7'd0, 2'($urandom_range(0, 2)), 6'd8, 1'b0};
          step();
          wr_enable = 1'b0; tx_if.data_valid = 1'b0;
        end else begin
          send($urandom);
        end
        finish_frame(1'b1);
      end
    end

    // Back-to-back: valid held through the first frame is taken on the word_sent cycle.
    write_cfg(16'h0010);
    a0 = acc_cnt;
    tx_if.data_valid = 1'b1; tx_if.data_w = $urandom;
    for (int c = 0; c < 400 && acc_cnt < a0 + 2; c++) begin
      step();
      if (acc_cnt == a0 + 1) tx_if.data_w = 32'h0000_005A;
    end
    tx_if.data_valid = 1'b0;
    chk("b2b_accepts", acc_cnt, a0 + 2);
    finish_frame(1'b0);

    // Reset in the third bit cell's low phase.
    write_cfg(16'h0010);
    send($urandom);
    for (int c = 0; c < 64 && off < 38; c++) step();
    chk("mid_low", {31'd0, (rec[38] == 2'b11)}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_lines", {30'd0, zl, ol}, 32'd3);
    chk("rst_no_ws", {31'd0, tx_if.word_sent}, 32'd0);
    step();
    write_cfg(16'h0010);
    send(32'h0000_00A5);
    finish_frame(1'b0);
    chk("post_rst_par", {30'd0, rec[133]}, 32'd2);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
